// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// The optional signed mode is enabled with the SIGNED_MULT_EN macro.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the iteration counter for a given operand width.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the shift-and-add multiplier: sequencing, iteration count,
// registered busy/done and the load/step/last/commit strobes for the datapath.
module shift_add_mult_ctrl
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last,
    output logic commit
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t state;
    state_t next_state;
    logic [CW-1:0] count;

    // busy and done are registered from the next/current state so they line up
    // with the cycle the datapath actually updates the product.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (state == DONE);
            if (load) begin
                count <= '0;
            end else if (step && !last) begin
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                last = (count == LAST_COUNT);
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier with start/busy/done.
// Define SIGNED_MULT_EN to add the signed_mode port for two's-complement operation.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
`ifdef SIGNED_MULT_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic load;
    logic step;
    logic last;
    logic commit;

    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] acc;
    logic             sm_q;

    logic [WIDTH:0]   hi;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             shift_in;
    logic [2*WIDTH:0] acc_next;

    shift_add_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .load    (load),
        .step    (step),
        .last    (last),
        .commit  (commit)
    );

`ifdef SIGNED_MULT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sm_q <= 1'b0;
        end else if (load) begin
            sm_q <= signed_mode;
        end
    end
`else
    assign sm_q = 1'b0;
`endif

    // In signed mode the multiplier MSB carries negative weight, so the final
    // partial product is subtracted and the shift keeps the sign.
    always_comb begin
        hi       = acc[2*WIDTH:WIDTH];
        addend   = sm_q ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
        sum      = hi;
        if (acc[0]) begin
            if (sm_q && last) begin
                sum = hi - addend;
            end else begin
                sum = hi + addend;
            end
        end
        shift_in = sm_q ? sum[WIDTH] : 1'b0;
        acc_next = {shift_in, sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                mcand <= op_a;
                acc   <= {{(WIDTH+1){1'b0}}, op_b};
            end else if (step) begin
                acc <= acc_next;
            end
            if (commit) begin
                product <= acc[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult at WIDTH=4 and WIDTH=8, against an
// arithmetic reference model; signed checks are built when SIGNED_MULT_EN is defined.
module tb_shift_add_mult;

    logic        clk;
    logic        rst;
    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        sm4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    shift_add_mult #(.WIDTH(4)) dut4 (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .start       (start4),
        .op_a        (a4),
        .op_b        (b4),
`ifdef SIGNED_MULT_EN
        .signed_mode (sm4),
`endif
        .busy        (busy4),
        .done        (done4),
        .product     (product4)
    );

    shift_add_mult #(.WIDTH(8)) dut8 (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .start       (start8),
        .op_a        (a8),
        .op_b        (b8),
`ifdef SIGNED_MULT_EN
        .signed_mode (1'b0),
`endif
        .busy        (busy8),
        .done        (done8),
        .product     (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the mathematical product, truncated to 2*width bits.
    function automatic logic [15:0] ref_product(input int width, input int a, input int b, input bit sm);
        longint sa;
        longint sb;
        longint p;
        sa = a;
        sb = b;
        if (sm) begin
            if (a >= (1 << (width - 1))) sa = a - (1 << width);
            if (b >= (1 << (width - 1))) sb = b - (1 << width);
        end
        p = sa * sb;
        p = p & ((longint'(1) << (2 * width)) - 1);
        return 16'(p);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One multiply from an idle DUT: returns product, edges from start to done, busy cycles.
    task automatic applyStimulus(input int width, input int a, input int b, input bit sm,
                                 output logic [15:0] prod, output int lat, output int nbusy);
        logic cur_done;
        logic cur_busy;
        @(negedge clk);
        if (width == 8) begin
            start8 = 1'b1;
            a8 = a[7:0];
            b8 = b[7:0];
        end else begin
            start4 = 1'b1;
            a4 = a[3:0];
            b4 = b[3:0];
            sm4 = sm;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        lat = 0;
        nbusy = 0;
        cur_done = (width == 8) ? done8 : done4;
        while (!cur_done && lat < 40) begin
            cur_busy = (width == 8) ? busy8 : busy4;
            if (cur_busy) nbusy++;
            @(negedge clk);
            lat++;
            cur_done = (width == 8) ? done8 : done4;
        end
        prod = (width == 8) ? product8 : {8'h00, product4};
    endtask

    initial begin
        logic [15:0] prod;
        int lat;
        int nbusy;
        int n;
        int ndone;
        int dk;
        logic [7:0] got;
        int ra;
        int rb;
        bit rsm;

        rst = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = '0;
        b4 = '0;
        sm4 = 1'b0;
        a8 = '0;
        b8 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy4", 32'(busy4), 32'd0);
        checkOutput("reset_done4", 32'(done4), 32'd0);
        checkOutput("reset_product4", 32'(product4), 32'd0);
        checkOutput("reset_product8", 32'(product8), 32'd0);
        rst = 1'b0;
        $display("[TB] reset checked");

        applyStimulus(4, 15, 15, 1'b0, prod, lat, nbusy);
        checkOutput("15x15_product", 32'(prod), 32'h00E1);
        checkOutput("15x15_latency", 32'(lat), 32'd5);
        checkOutput("15x15_busy_cycles", 32'(nbusy), 32'd5);
        checkOutput("15x15_busy_low_at_done", 32'(busy4), 32'd0);
        @(negedge clk);
        checkOutput("done_single_pulse", 32'(done4), 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'd0;
        b4 = 4'd9;
        n = 0;
        @(negedge clk);
        while (!done4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_first_product", 32'(product4), 32'd0);
        a4 = 4'd9;
        b4 = 4'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 40);
        start4 = 1'b0;
        checkOutput("b2b_spacing", 32'(n), 32'd6);
        checkOutput("b2b_second_product", 32'(product4), 32'd0);
        repeat (2) @(negedge clk);

        // Start re-asserted while busy must be ignored.
        start4 = 1'b1;
        a4 = 4'd3;
        b4 = 4'd5;
        @(negedge clk);
        ndone = 0;
        dk = -1;
        got = '0;
        for (int k = 0; k < 16; k++) begin
            if (done4) begin
                ndone++;
                dk = k;
                got = product4;
            end
            if (k >= 1 && k <= 3) begin
                start4 = 1'b1;
                a4 = 4'd7;
            end else begin
                start4 = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("ignore_start_dones", 32'(ndone), 32'd1);
        checkOutput("ignore_start_done_edge", 32'(dk), 32'd5);
        checkOutput("ignore_start_product", 32'(got), 32'd15);

        // Reset in the middle of a multiply.
        start4 = 1'b1;
        a4 = 4'd13;
        b4 = 4'd11;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", 32'(busy4), 32'd0);
        checkOutput("midreset_done", 32'(done4), 32'd0);
        checkOutput("midreset_product", 32'(product4), 32'd0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        checkOutput("midreset_no_done", 32'(ndone), 32'd0);
        applyStimulus(4, 2, 6, 1'b0, prod, lat, nbusy);
        checkOutput("after_reset_2x6", 32'(prod), 32'd12);

        applyStimulus(8, 255, 255, 1'b0, prod, lat, nbusy);
        checkOutput("w8_255x255_product", 32'(prod), 32'hFE01);
        checkOutput("w8_255x255_latency", 32'(lat), 32'd9);
        applyStimulus(8, 128, 2, 1'b0, prod, lat, nbusy);
        checkOutput("w8_128x2_product", 32'(prod), 32'h0100);

`ifdef SIGNED_MULT_EN
        applyStimulus(4, 8, 8, 1'b1, prod, lat, nbusy);
        checkOutput("signed_m8xm8", 32'(prod), 32'h40);
        checkOutput("signed_latency", 32'(lat), 32'd5);
        applyStimulus(4, 8, 7, 1'b1, prod, lat, nbusy);
        checkOutput("signed_m8x7", 32'(prod), 32'hC8);
        applyStimulus(4, 15, 1, 1'b1, prod, lat, nbusy);
        checkOutput("signed_m1x1", 32'(prod), 32'hFF);
        applyStimulus(4, 8, 8, 1'b0, prod, lat, nbusy);
        checkOutput("unsigned_8x8", 32'(prod), 32'h40);
        applyStimulus(4, 15, 15, 1'b0, prod, lat, nbusy);
        checkOutput("unsigned_15x15", 32'(prod), 32'hE1);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
`ifdef SIGNED_MULT_EN
            rsm = bit'($urandom_range(0, 1));
`else
            rsm = 1'b0;
`endif
            applyStimulus(4, ra, rb, rsm, prod, lat, nbusy);
            checkOutput($sformatf("rand4_%0d_%0dx%0d_s%0d", i, ra, rb, rsm), 32'(prod), 32'(ref_product(4, ra, rb, rsm)));
            checkOutput($sformatf("rand4_%0d_latency", i), 32'(lat), 32'd5);
        end

        for (int i = 0; i < 12; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            applyStimulus(8, ra, rb, 1'b0, prod, lat, nbusy);
            checkOutput($sformatf("rand8_%0d_%0dx%0d", i, ra, rb), 32'(prod), 32'(ref_product(8, ra, rb, 1'b0)));
            checkOutput($sformatf("rand8_%0d_busy_cycles", i), 32'(nbusy), 32'd9);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
